// File: rtl/seq_gen_if.sv
// Control and serial-output bundle for seq_gen: start/abort request with run
// parameters in, registered serial line and status out.
interface seq_gen_if #(
  parameter int WIDTH = 4,
  parameter int RPT_W = 3,
  parameter int GAP_W = 3
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [RPT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_n, gap,
    input  ser_out, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_n, gap,
    output ser_out, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB first,
// optionally repeating it with an idle gap, then pulses done for one cycle.
module seq_gen #(
  parameter int WIDTH = 4,
  parameter int RPT_W = 3,
  parameter int GAP_W = 3
) (
  input logic        clk,
  input logic        rst,
  seq_gen_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  // shreg always holds the bits still to be sent after the one on ser_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      rpt_cnt     <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      bus.ser_out <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            pat_q       <= bus.pattern;
            shreg       <= bus.pattern << 1;
            bus.ser_out <= bus.pattern[WIDTH-1];
            rpt_cnt     <= bus.repeat_n;
            gap_q       <= bus.gap;
            bit_cnt     <= LAST;
            bus.busy    <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            bus.ser_out <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else if (bit_cnt != '0) begin
            bus.ser_out <= shreg[WIDTH-1];
            shreg       <= shreg << 1;
            bit_cnt     <= bit_cnt - CNT_W'(1);
          end else if (rpt_cnt != '0) begin
            rpt_cnt <= rpt_cnt - RPT_W'(1);
            bit_cnt <= LAST;
            if (gap_q == '0) begin
              // next copy's MSB follows the last bit with no bubble
              bus.ser_out <= pat_q[WIDTH-1];
              shreg       <= pat_q << 1;
            end else begin
              bus.ser_out <= 1'b0;
              shreg       <= pat_q;
              gap_cnt     <= gap_q;
              state       <= GAP;
            end
          end else begin
            bus.ser_out <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        GAP: begin
          if (bus.abort) begin
            bus.ser_out <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            // gap_cnt==1 marks the final idle cycle; MSB goes out next
            if (gap_cnt == GAP_W'(1)) begin
              bus.ser_out <= shreg[WIDTH-1];
              shreg       <= shreg << 1;
              state       <= SHIFT;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: hand-computed per-cycle ser_out/busy/done
// sequences checked with immediate assertions.
module tb_seq_gen;
  localparam int WIDTH = 4;
  localparam int RPT_W = 3;
  localparam int GAP_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_gen_if #(.WIDTH(WIDTH), .RPT_W(RPT_W), .GAP_W(GAP_W)) bus ();

  seq_gen #(.WIDTH(WIDTH), .RPT_W(RPT_W), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic b, input logic d);
    chk({tag, ".ser"},  bus.ser_out, s);
    chk({tag, ".busy"}, bus.busy,    b);
    chk({tag, ".done"}, bus.done,    d);
  endtask

  // n cycles; bit n-1 of each vector is the expectation for the first cycle
  task automatic run(input string tag, input int n,
                     input logic [15:0] s, input logic [15:0] b, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk_all($sformatf("%s[c%0d]", tag, i + 1), s[n-1-i], b[n-1-i], d[n-1-i]);
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    bus.pattern  = 4'b1011;
    bus.repeat_n = '0;
    bus.gap      = '0;

    // reset held with start asserted
    tick();
    chk_all("rst_t6", 1'b0, 1'b0, 1'b0);
    #2;
    chk_all("rst_t8", 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;

    run("single", 6, 16'b101100, 16'b111100, 16'b000010);

    bus.pattern = 4'b1011; bus.repeat_n = 3'd1; bus.gap = 3'd2; bus.start = 1'b1;
    run("rpt_gap", 12, 16'b101100101100, 16'b111111111100, 16'b000000000010);

    bus.pattern = 4'b1101; bus.repeat_n = 3'd2; bus.gap = 3'd0; bus.start = 1'b1;
    run("b2b", 14, 16'b11011101110100, 16'b11111111111100, 16'b00000000000010);

    // live inputs change and start re-pulses mid-run
    bus.pattern = 4'b1011; bus.repeat_n = 3'd0; bus.gap = 3'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("cap[c1]", 1'b1, 1'b1, 1'b0);
    bus.pattern = 4'b0000; bus.repeat_n = 3'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("cap[c2]", 1'b0, 1'b1, 1'b0);
    run("cap_tail", 7, 16'b1100000, 16'b1100000, 16'b0010000);

    // abort sampled at the edge ending the 2nd bit
    bus.pattern = 4'b1011; bus.repeat_n = 3'd0; bus.gap = 3'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("abort[c1]", 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("abort[c2]", 1'b0, 1'b1, 1'b0);
    bus.abort = 1'b1;
    run("abort_after", 4, 16'b0000, 16'b0000, 16'b0000);
    bus.start = 1'b1;
    run("abort_rerun", 6, 16'b101100, 16'b111100, 16'b000010);

    // asynchronous reset during the gap
    bus.pattern = 4'b1011; bus.repeat_n = 3'd1; bus.gap = 3'd3; bus.start = 1'b1;
    run("arst_run", 5, 16'b10110, 16'b11110 | 16'b00001, 16'b00000);
    #2;
    rst = 1'b0;
    #1;
    chk_all("arst_now", 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    run("arst_idle", 5, 16'b00000, 16'b00000, 16'b00000);
    bus.repeat_n = 3'd0; bus.gap = 3'd0; bus.start = 1'b1;
    run("arst_rerun", 6, 16'b101100, 16'b111100, 16'b000010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete within 20000 time units");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial bit-pattern transmitter: the driving end of the serial sequence detector. On a start request it captures a WIDTH-bit pattern and shifts it out MSB first, one bit per clock, on a single-bit line. It optionally repeats the pattern with a programmable idle gap between copies, and then flags completion. It produces detector stimulus in-system and in benches.

## Interface
- WIDTH, 4: pattern length in bits (≥2).
- RPT_W, 3: width of the repeat-count field.
- GAP_W, 3: width of the inter-pattern gap field.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in SHIFT and GAP.
- pattern  in  WIDTH  pattern to send, captured on accepted start.
- repeat_n  in  RPT_W  extra copies; total copies = repeat_n+1, captured on start.
- gap  in  GAP_W  idle cycles between copies, captured on start; 0 = back-to-back.
- ser_out  out  1  serial data to the detector input; registered.
- busy  out  1  high in SHIFT and GAP; registered.
- done  out  1  one-cycle completion pulse; registered.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: ser_out=0, busy=0, done=0. start=1 at an edge loads the shift register, the copies-remaining counter (repeat_n), the gap value and the bit counter (WIDTH-1), then moves to SHIFT.
- SHIFT: ser_out = current MSB of the shift register. Each cycle the register shifts left and the bit counter decrements.
  - When the bit counter is 0 and copies-remaining is >0: decrement copies-remaining and reload the shift register from the captured pattern, not the live input.
    - If the captured gap is 0: stay in SHIFT, so the next copy's MSB follows with no bubble.
    - Otherwise: go to GAP with the gap counter set to gap.
  - When the bit counter is 0 and copies-remaining is 0: go to DONE.
- GAP: ser_out=0 and busy=1. The gap counter decrements each cycle. Leave for SHIFT after exactly gap cycles.
- DONE: done=1, busy=0, ser_out=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- abort=1 in SHIFT or GAP: next state is IDLE with ser_out=0 and busy=0. No done pulse is produced.
- start while busy or in DONE is ignored. Changes to pattern, repeat_n or gap after capture have no effect on the current run.
- Reset (rst=0, any time): immediately forces IDLE, ser_out=0, busy=0, done=0, and clears all counters. No bits are emitted until the first accepted start after reset deasserts.

## Timing
- Start accepted at edge E0: the first bit (pattern MSB) is on ser_out after E0 and stays valid through edge E1.
- Bit k (k=0 is the MSB) is valid in cycle E_k..E_{k+1}.
- With R = repeat_n+1 copies, busy stays high for R·WIDTH + (R−1)·gap cycles after E0.
- done rises at the edge immediately after the last bit cycle and is high for one cycle.
- Earliest next accepted start is the edge after done falls, which is 2 cycles after the last bit.
- ser_out, busy and done are flop outputs with no combinational path from inputs.
- abort sampled at edge Ea makes outputs IDLE-valued after Ea.

## Test plan
- Reset: hold rst=0 for 9 time units while start=1 → ser_out=0, busy=0, done=0 throughout. After release, start=1 with WIDTH=4 and pattern=4'b1011 → ser_out = 1,0,1,1 on cycles 1–4, busy=1 on cycles 1–4, done=1 on cycle 5.
- Repeat with gap: pattern=1011, repeat_n=1, gap=2 → ser_out = 1,0,1,1,0,0,1,0,1,1, busy high 10 cycles, done on cycle 11.
- Back-to-back: pattern=1101, repeat_n=2, gap=0 → 12 contiguous bits 110111011101, done on cycle 13.
- Capture and ignore: change pattern to 0000 and pulse start during cycle 2 of a 1011 run → output still 1011, one done pulse, no second run.
- Abort: abort=1 at the edge ending the 2nd bit of 1011 → ser_out=0 and busy=0 from the next cycle. done stays 0. A following start sends a full pattern.
- Async reset mid-run: rst=0 between edges during GAP → outputs go to 0 immediately, no done pulse. After release the block sits in IDLE until start.
